wb_sequencer: RTL and testbench

- Multi-cycle decode/execute/write-back controller that sits directly upstream of the 4x16-bit Register file (2 read ports, 1 write port).
- Accepts one 16-bit instruction at a time from the fetch stage via valid/ready.
- Drives the register file read addresses (reg1, reg2) and samples data1/data2.
- Computes the result and drives the write port (wreg, wdata, write_en) for exactly one cycle per writing instruction.

---
 rtl/wb_pkg.sv | 39 +++
 rtl/wb_sequencer_if.sv | 26 ++
 rtl/wb_alu.sv | 35 +++
 rtl/wb_sequencer.sv | 126 ++++++++++++
 tb/tb_wb_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared opcodes, instruction field positions and FSM encoding for the
// write-back sequencer and its ALU.
package wb_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_ADI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_WWD = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 10;
  localparam int RT_MSB  = 9;
  localparam int RT_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Immediate-form instructions write rt instead of rd.
  function automatic logic writes_rt(input logic [3:0] op);
    return (op == OP_ADI) || (op == OP_LHI);
  endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Fetch handshake plus register-file read/write bus seen by the sequencer.
interface wb_sequencer_if #(
  parameter int DW = 16,
  parameter int AW = 2
);
  logic [DW-1:0] inst;
  logic          inst_valid;
  logic          inst_ready;
  logic [AW-1:0] reg1;
  logic [AW-1:0] reg2;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic [AW-1:0] wreg;
  logic [DW-1:0] wdata;
  logic          write_en;

  modport master (
    input  inst, inst_valid, data1, data2,
    output inst_ready, reg1, reg2, wreg, wdata, write_en
  );

  modport slave (
    output inst, inst_valid, data1, data2,
    input  inst_ready, reg1, reg2, wreg, wdata, write_en
  );
endinterface

// File: rtl/wb_alu.sv
// Combinational result for the register-writing opcodes; other opcodes give 0.
module wb_alu
  import wb_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [7:0]    imm8,
  output logic [DW-1:0] result
);

  logic [DW-1:0] imm_sext_s;
  logic [DW-1:0] imm_high_s;

  assign imm_sext_s = {{(DW-8){imm8[7]}}, imm8};
  assign imm_high_s = {imm8, {(DW-8){1'b0}}};

  // Opcode-selected result, all arithmetic wrapping at DW bits
  always_comb begin
    result = {DW{1'b0}};
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_ORR:  result = a | b;
      OP_NOT:  result = ~a;
      OP_ADI:  result = a + imm_sext_s;
      OP_LHI:  result = imm_high_s;
      default: result = {DW{1'b0}};
    endcase
  end

endmodule

// File: rtl/wb_sequencer.sv
// Serialising decode/execute/write-back controller in front of a 4x16 register
// file; one instruction in flight, every visible output comes from a flop.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_sequencer_if.master       bus,
  output logic [DW-1:0]        output_port,
  output logic [DW-1:0]        num_inst,
  output logic                 is_halted,
  output logic                 illegal
);

  state_t        state_r;
  logic [DW-1:0] ir_r;
  logic          inst_ready_r;
  logic          write_en_r;
  logic [AW-1:0] wreg_r;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] output_port_r;
  logic [DW-1:0] num_inst_r;
  logic          halted_r;
  logic          illegal_r;
  logic [DW-1:0] alu_result_s;
  logic [3:0]    op_s;

  assign op_s = ir_r[OP_MSB:OP_LSB];

  wb_alu #(.DW(DW)) u_alu (
    .op     (op_s),
    .a      (bus.data1),
    .b      (bus.data2),
    .imm8   (ir_r[IMM_MSB:IMM_LSB]),
    .result (alu_result_s)
  );

  // Read addresses come straight from IR so they hold until the next accept.
  assign bus.reg1       = ir_r[RS_MSB:RS_LSB];
  assign bus.reg2       = ir_r[RT_MSB:RT_LSB];
  assign bus.inst_ready = inst_ready_r;
  assign bus.write_en   = write_en_r;
  assign bus.wreg       = wreg_r;
  assign bus.wdata      = wdata_r;
  assign output_port    = output_port_r;
  assign num_inst       = num_inst_r;
  assign is_halted      = halted_r;
  assign illegal        = illegal_r;

  // Sequencer FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      ir_r          <= {DW{1'b0}};
      inst_ready_r  <= 1'b1;
      write_en_r    <= 1'b0;
      wreg_r        <= {AW{1'b0}};
      wdata_r       <= {DW{1'b0}};
      output_port_r <= {DW{1'b0}};
      num_inst_r    <= {DW{1'b0}};
      halted_r      <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.inst_valid) begin
            ir_r         <= bus.inst;
            inst_ready_r <= 1'b0;
            state_r      <= ST_DECODE;
          end else begin
            inst_ready_r <= 1'b1;
          end
        end
        ST_DECODE: begin
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_NOT, OP_ADI, OP_LHI: begin
              wdata_r    <= alu_result_s;
              wreg_r     <= writes_rt(op_s) ? ir_r[RT_MSB:RT_LSB] : ir_r[RD_MSB:RD_LSB];
              write_en_r <= 1'b1;
              state_r    <= ST_WB;
            end
            OP_WWD: begin
              output_port_r <= bus.data1;
              num_inst_r    <= num_inst_r + DW'(1);
              inst_ready_r  <= 1'b1;
              state_r       <= ST_IDLE;
            end
            OP_HLT: begin
              num_inst_r <= num_inst_r + DW'(1);
              halted_r   <= 1'b1;
              state_r    <= ST_HALT;
            end
            default: begin
              illegal_r    <= 1'b1;
              inst_ready_r <= 1'b1;
              state_r      <= ST_IDLE;
            end
          endcase
        end
        ST_WB: begin
          write_en_r   <= 1'b0;
          num_inst_r   <= num_inst_r + DW'(1);
          inst_ready_r <= 1'b1;
          state_r      <= ST_IDLE;
        end
        ST_HALT: begin
          write_en_r   <= 1'b0;
          inst_ready_r <= 1'b0;
          state_r      <= ST_HALT;
        end
        default: begin
          write_en_r   <= 1'b0;
          inst_ready_r <= 1'b1;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench: a behavioural register file answers reads and absorbs writes,
// and each instruction is checked for write pulse, latency, address and data.
module tb_wb_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] output_port;
  logic [15:0] num_inst;
  logic        is_halted;
  logic        illegal;

  int vectors;
  int miscompares;

  logic [15:0] rf [4] = '{16'd5, 16'd15, 16'd10, 16'd0};

  wb_sequencer_if #(.DW(16), .AW(2)) bus ();

  wb_sequencer #(.DW(16), .AW(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .output_port (output_port),
    .num_inst    (num_inst),
    .is_halted   (is_halted),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.data1 = rf[bus.reg1];
  assign bus.data2 = rf[bus.reg2];

  // Register file write port
  always @(posedge clk) begin
    if (bus.write_en) rf[bus.wreg] <= bus.wdata;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [15:0] word);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.inst_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_vec("accept_ready", 32'(bus.inst_ready), 32'd1);
    bus.inst       = word;
    bus.inst_valid = 1'b1;
    @(posedge clk);
    #1 bus.inst_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [15:0] word, input int exp_writes,
                     input logic [1:0] exp_wreg, input logic [15:0] exp_wdata);
    int pulses;
    int first;
    logic [1:0]  got_wreg;
    logic [15:0] got_wdata;
    logic [15:0] w;
    pulses    = 0;
    first     = -1;
    got_wreg  = 2'd0;
    got_wdata = 16'd0;
    w         = word;
    accept(word);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_vec({tag, "_reg1"}, 32'(bus.reg1), 32'(w[11:10]));
        check_vec({tag, "_reg2"}, 32'(bus.reg2), 32'(w[9:8]));
      end
      if (bus.write_en) begin
        pulses++;
        if (first < 0) begin
          first     = c;
          got_wreg  = bus.wreg;
          got_wdata = bus.wdata;
        end
      end
    end
    check_vec({tag, "_pulses"}, 32'(pulses), 32'(exp_writes));
    if (exp_writes > 0) begin
      check_vec({tag, "_latency"}, 32'(first), 32'd3);
      check_vec({tag, "_wreg"}, 32'(got_wreg), 32'(exp_wreg));
      check_vec({tag, "_wdata"}, 32'(got_wdata), 32'(exp_wdata));
    end
  endtask

  initial begin
    int pulses;
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    bus.inst       = 16'h0000;
    bus.inst_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_vec("rst_write_en", 32'(bus.write_en), 32'd0);
    check_vec("rst_num_inst", 32'(num_inst), 32'd0);
    check_vec("rst_halted", 32'(is_halted), 32'd0);
    check_vec("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_vec("rst_ready", 32'(bus.inst_ready), 32'd1);

    // R1=15, R2=10: ADD r3 = r1 + r2
    run("add", 16'h06C0, 1, 2'd3, 16'd25);
    check_vec("add_num", 32'(num_inst), 32'd1);
    run("wwd15", 16'h7400, 0, 2'd0, 16'd0);
    check_vec("wwd15_port", 32'(output_port), 32'd15);
    check_vec("wwd15_num", 32'(num_inst), 32'd2);

    // Reset while the ADD sits in EXEC
    accept(16'h06C0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_vec("midrst_write_en", 32'(bus.write_en), 32'd0);
    check_vec("midrst_num", 32'(num_inst), 32'd0);
    check_vec("midrst_port", 32'(output_port), 32'd0);
    check_vec("midrst_wreg", 32'(bus.wreg), 32'd0);
    check_vec("midrst_wdata", 32'(bus.wdata), 32'd0);
    check_vec("midrst_reg1", 32'(bus.reg1), 32'd0);
    check_vec("midrst_reg2", 32'(bus.reg2), 32'd0);
    check_vec("midrst_ready", 32'(bus.inst_ready), 32'd1);
    reset  = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.write_en) pulses++;
    end
    check_vec("midrst_nowrite", 32'(pulses), 32'd0);
    check_vec("midrst_r3", 32'(rf[3]), 32'd25);

    // R0=5: ADI r1 = r0 + (-2); LHI r2 = 0x1200
    run("adi", 16'h51FE, 1, 2'd1, 16'd3);
    run("lhi", 16'h6212, 1, 2'd2, 16'h1200);
    // r1 = r1 - r1 = 0; r2 = r1 + 1; r3 = r1 - r2
    run("sub0", 16'h1540, 1, 2'd1, 16'h0000);
    run("adi1", 16'h5601, 1, 2'd2, 16'h0001);
    run("subwrap", 16'h16C0, 1, 2'd3, 16'hFFFF);
    check_vec("sub_num", 32'(num_inst), 32'd5);
    run("wwdffff", 16'h7C00, 0, 2'd0, 16'd0);
    check_vec("wwdffff_port", 32'(output_port), 32'hFFFF);
    check_vec("wwdffff_num", 32'(num_inst), 32'd6);
    // r0 = 0xFFFF & 1; r1 = 0xA500; r2 = r1 | r0; r0 = ~r1; r1 = r3 + r0
    run("and", 16'h2E00, 1, 2'd0, 16'h0001);
    run("lhia5", 16'h61A5, 1, 2'd1, 16'hA500);
    run("orr", 16'h3480, 1, 2'd2, 16'hA501);
    run("not", 16'h4400, 1, 2'd0, 16'h5AFF);
    run("addovf", 16'h0C40, 1, 2'd1, 16'h5AFE);
    check_vec("alu_num", 32'(num_inst), 32'd11);

    run("illegal", 16'h9000, 0, 2'd0, 16'd0);
    check_vec("illegal_flag", 32'(illegal), 32'd1);
    check_vec("illegal_num", 32'(num_inst), 32'd11);
    // r3 = 0x5AFF + 0xA501 wraps to 0
    run("addwrap", 16'h02C0, 1, 2'd3, 16'h0000);
    check_vec("illegal_sticky", 32'(illegal), 32'd1);
    check_vec("addwrap_num", 32'(num_inst), 32'd12);

    run("hlt", 16'hF000, 0, 2'd0, 16'd0);
    check_vec("hlt_halted", 32'(is_halted), 32'd1);
    check_vec("hlt_num", 32'(num_inst), 32'd13);
    bus.inst       = 16'h06C0;
    bus.inst_valid = 1'b1;
    pulses         = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.write_en || bus.inst_ready) pulses++;
    end
    bus.inst_valid = 1'b0;
    check_vec("halt_quiet", 32'(pulses), 32'd0);
    check_vec("halt_ready", 32'(bus.inst_ready), 32'd0);
    check_vec("halt_num", 32'(num_inst), 32'd13);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_vec("rst2_halted", 32'(is_halted), 32'd0);
    check_vec("rst2_illegal", 32'(illegal), 32'd0);
    check_vec("rst2_ready", 32'(bus.inst_ready), 32'd1);
    // r3 = 0x5AFE + 0xA501
    run("postrst", 16'h06C0, 1, 2'd3, 16'hFFFF);
    check_vec("postrst_num", 32'(num_inst), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
